// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed driver for a bank of common-select
//               seven-segment digits. Captures a packed hex word and per-digit
//               decimal points into shadow registers. It scans one digit per
//               slot through a one-hot select bus, and inserts a dead time at
//               the start of every slot to suppress ghosting.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DIGITS    - number of digits (1..8)
//               SCAN_DIV  - clock cycles per digit slot (>= 2)
//               BLANK_CYC - dead-time cycles at slot start (< SCAN_DIV)
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               data       - hex nibbles, nibble i belongs to digit i
//               dp_in      - decimal-point enables, bit i for digit i
//               load       - capture data/dp_in into shadow registers
//               blank_in   - force the display dark while high
//               sela       - one-hot digit select, active-high, registered
//               led        - {dp, a..g}, active-high, registered
//               frame_done - one-cycle pulse when the scan wraps to digit 0
// Options     : SEG7_LZS_EN - when defined, leading-zero suppression is
//               compiled in (digit 0 is never suppressed; dp still shown)
// ============================================================================
module seg7_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    input  logic                blank_in,
    output logic [DIGITS-1:0]   sela,
    output logic [7:0]          led,
    output logic                frame_done
);

    localparam int                 c_cnt_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                 c_idx_w    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [DIGITS-1:0]  c_sel_one  = DIGITS'(1);

    logic [4*DIGITS-1:0] r_sh_data_q, w_sh_data_d;
    logic [DIGITS-1:0]   r_sh_dp_q,   w_sh_dp_d;
    logic [c_cnt_w-1:0]  r_cnt_q,     w_cnt_d;
    logic [c_idx_w-1:0]  r_idx_q,     w_idx_d;
    logic [3:0]          r_snap_nib_q, w_snap_nib_d;
    logic                r_snap_dp_q,  w_snap_dp_d;
    logic [DIGITS-1:0]   r_sela_q,     w_sela_d;
    logic [7:0]          r_led_q,      w_led_d;
    logic                r_frame_done_q, w_frame_done_d;

    logic                w_slot_start;
    logic                w_cnt_wrap;
    logic                w_in_dead;
    logic                w_suppress;

    function automatic logic [6:0] f_seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h72;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h73;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

`ifdef SEG7_LZS_EN
    logic              r_snap_lz_q, w_snap_lz_d;
    logic [DIGITS-1:0] w_lz_vec;
    logic              w_zero_above;

    // A digit is a leading zero when it and every higher nibble are zero.
    always_comb begin
        w_zero_above = 1'b1;
        w_lz_vec     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above & (r_sh_data_q[4*i +: 4] == 4'h0);
            if (i > 0) begin
                w_lz_vec[i] = w_zero_above;
            end
        end
        w_snap_lz_d = w_slot_start ? w_lz_vec[r_idx_q] : r_snap_lz_q;
        w_suppress  = w_snap_lz_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_lz_q <= 1'b0;
        end else begin
            r_snap_lz_q <= w_snap_lz_d;
        end
    end
`else
    always_comb begin
        w_suppress = 1'b0;
    end
`endif

    always_comb begin
        w_sh_data_d = load ? data  : r_sh_data_q;
        w_sh_dp_d   = load ? dp_in : r_sh_dp_q;

        w_slot_start = (r_cnt_q == '0);
        w_cnt_wrap   = (r_cnt_q == c_cnt_last);
        w_cnt_d      = w_cnt_wrap ? '0 : r_cnt_q + c_cnt_one;

        w_idx_d = r_idx_q;
        if (w_cnt_wrap) begin
            w_idx_d = (r_idx_q == c_idx_last) ? '0 : r_idx_q + c_idx_one;
        end

        // The snapshot mux is used directly for the output encoding so that
        // a slot with no dead time still shows its own digit from cnt == 0.
        w_snap_nib_d = w_slot_start ? r_sh_data_q[{r_idx_q, 2'b00} +: 4] : r_snap_nib_q;
        w_snap_dp_d  = w_slot_start ? r_sh_dp_q[r_idx_q] : r_snap_dp_q;

        w_in_dead = (32'(r_cnt_q) < 32'(BLANK_CYC));

        w_sela_d = '0;
        w_led_d  = '0;
        if (!blank_in && !w_in_dead) begin
            w_sela_d = c_sel_one << r_idx_q;
            w_led_d  = {w_snap_dp_d, (w_suppress ? 7'h00 : f_seg7(w_snap_nib_d))};
        end

        w_frame_done_d = w_cnt_wrap && (r_idx_q == c_idx_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_data_q    <= '0;
            r_sh_dp_q      <= '0;
            r_cnt_q        <= '0;
            r_idx_q        <= '0;
            r_snap_nib_q   <= 4'h0;
            r_snap_dp_q    <= 1'b0;
            r_sela_q       <= '0;
            r_led_q        <= 8'h00;
            r_frame_done_q <= 1'b0;
        end else begin
            r_sh_data_q    <= w_sh_data_d;
            r_sh_dp_q      <= w_sh_dp_d;
            r_cnt_q        <= w_cnt_d;
            r_idx_q        <= w_idx_d;
            r_snap_nib_q   <= w_snap_nib_d;
            r_snap_dp_q    <= w_snap_dp_d;
            r_sela_q       <= w_sela_d;
            r_led_q        <= w_led_d;
            r_frame_done_q <= w_frame_done_d;
        end
    end

    assign sela       = r_sela_q;
    assign led        = r_led_q;
    assign frame_done = r_frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver with DIGITS=4,
//               SCAN_DIV=8, BLANK_CYC=2. Expected outputs are queued per clock
//               edge (counted from reset release) and popped as the DUT
//               reaches that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        blank_in = 1'b0;
    logic [3:0]  sela;
    logic [7:0]  led;
    logic        frame_done;

    typedef struct {
        int         at;
        logic [3:0] sela;
        logic [7:0] led;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   edges;
    int   n_total = 0;
    int   n_bad   = 0;

    seg7_scan_driver #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .dp_in      (dp_in),
        .load       (load),
        .blank_in   (blank_in),
        .sela       (sela),
        .led        (led),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; cnt/idx are a pure function of it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h7E; 4'h1: s = 7'h30; 4'h2: s = 7'h6D; 4'h3: s = 7'h79;
            4'h4: s = 7'h33; 4'h5: s = 7'h5B; 4'h6: s = 7'h5F; 4'h7: s = 7'h72;
            4'h8: s = 7'h7F; 4'h9: s = 7'h73; 4'hA: s = 7'h77; 4'hB: s = 7'h1F;
            4'hC: s = 7'h4E; 4'hD: s = 7'h3D; 4'hE: s = 7'h4F; default: s = 7'h47;
        endcase
        return s;
    endfunction

    // Expected outputs just after rising edge n: they reflect the slot
    // position one cycle earlier (position n-1 since release).
    function automatic exp_t f_expect(int n, logic [15:0] d, logic [3:0] dp, bit blk);
        exp_t        e;
        int          c;
        int          dg;
        logic [15:0] hi;
        e.at   = n;
        e.fd   = (n % FRAME == 0);
        e.sela = 4'b0000;
        e.led  = 8'h00;
        c  = (n - 1) % SCAN_DIV;
        dg = ((n - 1) / SCAN_DIV) % DIGITS;
        if (!blk && c >= BLANK_CYC) begin
            e.sela = 4'b0001 << dg;
            e.led  = {dp[dg], f_seg(d[dg*4 +: 4])};
`ifdef SEG7_LZS_EN
            hi = d >> (4 * dg);
            if (dg > 0 && hi == 16'h0) e.led[6:0] = 7'h00;
`else
            hi = 16'h0;
`endif
        end
        return e;
    endfunction

    function automatic int next_base();
        int b;
        b = edges + 1;
        while (b % FRAME != 1) b++;
        return b;
    endfunction

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        @(negedge clk);
        data  = d;
        dp_in = dp;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_total++;
            if (sela !== 4'h0 || led !== 8'h00 || frame_done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: got sela=%b led=%h fd=%b, want 0000/00/0", sela, led, frame_done);
            end
        end
        rst_n = 1'b1;
        for (int n = 1; n <= FRAME + 1; n++) exp_q.push_back(f_expect(n, 16'h0, 4'h0, 1'b0));
        while (exp_q.size() != 0) begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at <= edges) begin
                e = exp_q.pop_front();
                n_total++;
                if (e.at != edges || sela !== e.sela || led !== e.led || frame_done !== e.fd) begin
                    n_bad++;
                    $display("FAIL reset_scan edge=%0d: got sela=%b led=%h fd=%b, want sela=%b led=%h fd=%b",
                             edges, sela, led, frame_done, e.sela, e.led, e.fd);
                end
            end
        end
    endtask

    task automatic test_pattern(input string name, input logic [15:0] d, input logic [3:0] dp);
        exp_t e;
        int   b;
        do_load(d, dp);
        b = next_base();
        for (int n = b; n < b + FRAME; n++) exp_q.push_back(f_expect(n, d, dp, 1'b0));
        while (exp_q.size() != 0) begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at <= edges) begin
                e = exp_q.pop_front();
                n_total++;
                if (e.at != edges || sela !== e.sela || led !== e.led || frame_done !== e.fd) begin
                    n_bad++;
                    $display("FAIL %s edge=%0d: got sela=%b led=%h fd=%b, want sela=%b led=%h fd=%b",
                             name, edges, sela, led, frame_done, e.sela, e.led, e.fd);
                end
            end
        end
    endtask

    task automatic test_midslot_load();
        exp_t e;
        int   b;
        do_load(16'hAAAA, 4'h0);
        b = next_base();
        for (int n = b; n < b + FRAME; n++)
            exp_q.push_back(f_expect(n, (n - b >= 2 * SCAN_DIV) ? 16'hFFFF : 16'hAAAA, 4'h0, 1'b0));
        fork
            begin
                while (exp_q.size() != 0) begin
                    @(negedge clk);
                    while (exp_q.size() != 0 && exp_q[0].at <= edges) begin
                        e = exp_q.pop_front();
                        n_total++;
                        if (e.at != edges || sela !== e.sela || led !== e.led || frame_done !== e.fd) begin
                            n_bad++;
                            $display("FAIL midslot_load edge=%0d: got sela=%b led=%h fd=%b, want sela=%b led=%h fd=%b",
                                     edges, sela, led, frame_done, e.sela, e.led, e.fd);
                        end
                    end
                end
            end
            begin
                // State after edge b+11 is slot 1, cnt 4.
                while (edges != b + 11) @(negedge clk);
                data = 16'hFFFF;
                load = 1'b1;
                @(negedge clk);
                load = 1'b0;
            end
        join
    endtask

    task automatic test_blank();
        exp_t e;
        int   b;
        do_load(16'h1234, 4'h0);
        b = next_base();
        for (int n = b; n < b + 48; n++)
            exp_q.push_back(f_expect(n, 16'h1234, 4'h0, (n >= b + 23 && n <= b + 42)));
        fork
            begin
                while (exp_q.size() != 0) begin
                    @(negedge clk);
                    while (exp_q.size() != 0 && exp_q[0].at <= edges) begin
                        e = exp_q.pop_front();
                        n_total++;
                        if (e.at != edges || sela !== e.sela || led !== e.led || frame_done !== e.fd) begin
                            n_bad++;
                            $display("FAIL blank edge=%0d: got sela=%b led=%h fd=%b, want sela=%b led=%h fd=%b",
                                     edges, sela, led, frame_done, e.sela, e.led, e.fd);
                        end
                    end
                end
            end
            begin
                while (edges != b + 22) @(negedge clk);
                blank_in = 1'b1;
                while (edges != b + 42) @(negedge clk);
                blank_in = 1'b0;
            end
        join
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   b;
        do_load(16'h1234, 4'h0);
        b = next_base();
        while (edges != b + 12) @(negedge clk);
        n_total++;
        if (sela !== 4'b0010 || led !== 8'h79) begin
            n_bad++;
            $display("FAIL async_pre: got sela=%b led=%h, want 0010/79", sela, led);
        end
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (sela !== 4'h0 || led !== 8'h00 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL async_clear: got sela=%b led=%h fd=%b, want 0000/00/0", sela, led, frame_done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Shadow registers were cleared, so digit 0 restarts showing zero.
        for (int n = 1; n <= SCAN_DIV; n++) exp_q.push_back(f_expect(n, 16'h0, 4'h0, 1'b0));
        while (exp_q.size() != 0) begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].at <= edges) begin
                e = exp_q.pop_front();
                n_total++;
                if (e.at != edges || sela !== e.sela || led !== e.led || frame_done !== e.fd) begin
                    n_bad++;
                    $display("FAIL async_restart edge=%0d: got sela=%b led=%h fd=%b, want sela=%b led=%h fd=%b",
                             edges, sela, led, frame_done, e.sela, e.led, e.fd);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pattern("digits", 16'h1234, 4'b0000);
        test_pattern("dp", 16'h1234, 4'b0100);
        test_midslot_load();
        test_blank();
        test_pattern("lzs", 16'h0070, 4'b0000);
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
